// File: rtl/seven_seg_scan_mux.sv
// Four-digit multiplexed seven-segment driver: prescaled anode scan, frame-latched
// digits, registered active-low segment decode with optional leading-zero blanking.
module seven_seg_scan_mux #(
   parameter int REFRESH_DIV = 100000,
   parameter bit BLANK_LEAD  = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] digits,
   input  logic [3:0]  dp_en,
   input  logic        en,
   output logic [6:0]  seg_cat,
   output logic        seg_dp,
   output logic [3:0]  seg_an,
   output logic [1:0]  scan_idx
);

   localparam logic [19:0] TC_VAL = 20'(REFRESH_DIV - 1);

   logic [19:0] presc_cnt;
   logic        tc;
   logic [15:0] shadow_digits;
   logic [3:0]  shadow_dp;
   logic [3:0]  lead_zero;
   logic [3:0]  cur_digit;
   logic        cur_blank;
   logic [6:0]  cur_cat;
   logic [3:0]  cur_an;

   function automatic logic [6:0] decode_seg(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0011000;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   assign tc = (presc_cnt == TC_VAL);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_cnt <= '0;
         scan_idx  <= '0;
      end else begin
         presc_cnt <= tc ? '0 : presc_cnt + 20'd1;
         if (tc)
            scan_idx <= scan_idx + 2'd1;
      end
   end

   // Shadow loads only on the 3->0 wrap edge so a whole frame shows one snapshot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_digits <= '0;
         shadow_dp     <= '0;
      end else if (tc && (scan_idx == 2'd3)) begin
         shadow_digits <= digits;
         shadow_dp     <= dp_en;
      end
   end

   always_comb begin
      lead_zero    = 4'b0000;
      lead_zero[3] = (shadow_digits[15:12] == 4'd0);
      lead_zero[2] = lead_zero[3] && (shadow_digits[11:8] == 4'd0);
      lead_zero[1] = lead_zero[2] && (shadow_digits[7:4] == 4'd0);
   end

   always_comb begin
      cur_digit = shadow_digits[{scan_idx, 2'b00} +: 4];
      cur_blank = BLANK_LEAD && lead_zero[scan_idx];
      cur_cat   = cur_blank ? 7'b1111111 : decode_seg(cur_digit);
      cur_an    = ~(4'b0001 << scan_idx);
   end

   // Anode and cathodes come from the same registered snapshot, so they always switch together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg_an  <= 4'b1111;
         seg_cat <= 7'b1111111;
         seg_dp  <= 1'b1;
      end else if (!en) begin
         seg_an  <= 4'b1111;
         seg_cat <= 7'b1111111;
         seg_dp  <= 1'b1;
      end else begin
         seg_an  <= cur_an;
         seg_cat <= cur_cat;
         seg_dp  <= ~shadow_dp[scan_idx];
      end
   end

endmodule

// File: tb/tb_seven_seg_scan_mux.sv
// Randomized self-checking bench for seven_seg_scan_mux against an edge-count
// arithmetic model of the scan, frame latch and decode rules.
module tb_seven_seg_scan_mux;

   localparam int R = 4;

   logic        clk;
   logic        rst;
   logic [15:0] digits;
   logic [3:0]  dp_en;
   logic        en;
   logic [6:0]  seg_cat;
   logic        seg_dp;
   logic [3:0]  seg_an;
   logic [1:0]  scan_idx;

   int checks;
   int errors;

   int          n_edge;
   logic [15:0] m_digits;
   logic [3:0]  m_dp;
   logic [6:0]  seg_tbl [10];

   seven_seg_scan_mux #(.REFRESH_DIV(R), .BLANK_LEAD(1'b1)) dut (
      .clk      (clk),
      .rst      (rst),
      .digits   (digits),
      .dp_en    (dp_en),
      .en       (en),
      .seg_cat  (seg_cat),
      .seg_dp   (seg_dp),
      .seg_an   (seg_an),
      .scan_idx (scan_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      n_edge   = 0;
      m_digits = 16'h0000;
      m_dp     = 4'b0000;
   endtask

   // One clock edge: model predicts outputs from the slot that was active before the edge.
   task automatic step_check();
      int pidx;
      int d;
      logic        blank;
      logic [3:0]  e_an;
      logic [6:0]  e_cat;
      logic        e_dp;
      @(posedge clk);
      #1;
      n_edge++;
      pidx  = ((n_edge - 1) / R) % 4;
      d     = int'((m_digits >> (4 * pidx)) & 16'hF);
      blank = (d > 9) || (pidx > 0 && (m_digits >> (4 * pidx)) == 16'h0);
      if (en) begin
         e_an  = 4'hF ^ 4'(1 << pidx);
         e_cat = blank ? 7'b1111111 : seg_tbl[d];
         e_dp  = ~m_dp[pidx];
      end else begin
         e_an  = 4'b1111;
         e_cat = 7'b1111111;
         e_dp  = 1'b1;
      end
      if (n_edge % (4 * R) == 0) begin
         m_digits = digits;
         m_dp     = dp_en;
      end
      check_val("seg_an", 32'(seg_an), 32'(e_an));
      check_val("seg_cat", 32'(seg_cat), 32'(e_cat));
      check_val("seg_dp", 32'(seg_dp), 32'(e_dp));
      check_val("scan_idx", 32'(scan_idx), 32'((n_edge / R) % 4));
   endtask

   task automatic run(input int cycles);
      for (int i = 0; i < cycles; i++) step_check();
   endtask

   task automatic reset_now();
      rst = 1'b1;
      #1;
      check_val("rst_an", 32'(seg_an), 32'h0000000F);
      check_val("rst_cat", 32'(seg_cat), 32'h0000007F);
      check_val("rst_dp", 32'(seg_dp), 32'h1);
      check_val("rst_idx", 32'(scan_idx), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   function automatic logic [15:0] rand_digits();
      logic [15:0] v;
      v = '0;
      for (int k = 0; k < 4; k++)
         if ($urandom_range(0, 1) == 1) v[4*k +: 4] = 4'($urandom_range(0, 15));
      return v;
   endfunction

   initial begin
      seg_tbl[0] = 7'b1000000; seg_tbl[1] = 7'b1111001; seg_tbl[2] = 7'b0100100;
      seg_tbl[3] = 7'b0110000; seg_tbl[4] = 7'b0011001; seg_tbl[5] = 7'b0010010;
      seg_tbl[6] = 7'b0000010; seg_tbl[7] = 7'b1111000; seg_tbl[8] = 7'b0000000;
      seg_tbl[9] = 7'b0011000;
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      digits = 16'h1234;
      dp_en  = 4'b0000;
      en     = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // first frame shows shadow zeros, then 1234 after the wrap
      run(2);
      check_val("first_an", 32'(seg_an), 32'hE);
      run(40);

      // mid-count reset, then scan order again
      run(3);
      @(posedge clk);
      #1;
      reset_now();
      run(1);
      check_val("post_rst_cat", 32'(seg_cat), 32'h40);
      run(31);

      // change inputs while slot 1 is active
      for (int i = 0; i < 4 * R && ((n_edge / R) % 4) != 1; i++) step_check();
      check_val("at_slot1", 32'(scan_idx), 32'h1);
      digits = 16'h5678;
      run(3 * 4 * R);

      digits = 16'h0070;
      run(3 * 4 * R);
      digits = 16'h00A5;
      run(3 * 4 * R);

      dp_en  = 4'b0100;
      digits = 16'h9081;
      run(2 * 4 * R);
      en = 1'b0;
      run(10);
      en = 1'b1;
      run(2 * 4 * R);

      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 7) == 0) digits = rand_digits();
         if ($urandom_range(0, 7) == 0) dp_en = 4'($urandom_range(0, 15));
         en = ($urandom_range(0, 9) != 0);
         if (i == 400) begin
            @(negedge clk);
            reset_now();
         end
         step_check();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
